// File: rtl/risc_alu.sv
// Accumulator-machine ALU: zero-latency result/flags for the datapath plus a
// one-cycle registered copy for the controller and debug.
module risc_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] alu_out,
  output logic             is_zero,
  output logic             carry,
  output logic [WIDTH-1:0] alu_out_r,
  output logic             is_zero_r,
  output logic             carry_r
);

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } op_e;

  logic [WIDTH:0] sum;

  assign sum = {1'b0, inA} + {1'b0, inB};

  // SKZ must see the accumulator before the operation, so the flag ignores opcode
  assign is_zero = (inA == '0);

  always_comb begin
    alu_out = inA;
    carry   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_out = sum[WIDTH-1:0];
        carry   = sum[WIDTH];
      end
      OP_AND:  alu_out = inA & inB;
      OP_XOR:  alu_out = inA ^ inB;
      OP_LDA:  alu_out = inB;
      default: alu_out = inA;
    endcase
  end

  // Accumulator is zero out of reset, hence is_zero_r resets high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_r <= '0;
      is_zero_r <= 1'b1;
      carry_r   <= 1'b0;
    end else begin
      alu_out_r <= alu_out;
      is_zero_r <= is_zero;
      carry_r   <= carry;
    end
  end

endmodule

// File: tb/tb_risc_alu.sv
// Self-checking bench for risc_alu: directed table, randomized model compare,
// and asynchronous reset corner cases.
module tb_risc_alu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] inA = 8'h00;
  logic [7:0] inB = 8'h00;
  logic [2:0] opcode = 3'b000;
  logic [7:0] alu_out, alu_out_r;
  logic       is_zero, carry, is_zero_r, carry_r;

  int checks = 0;
  int errors = 0;

  risc_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .inA(inA), .inB(inB), .opcode(opcode),
    .alu_out(alu_out), .is_zero(is_zero), .carry(carry),
    .alu_out_r(alu_out_r), .is_zero_r(is_zero_r), .carry_r(carry_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] out;
    logic       z;
    logic       c;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference from the opcode table using plain integer arithmetic
  task automatic model(input int a, input int b, input int op,
                       output int out, output int z, output int c);
    int s;
    s = a + b;
    c = 0;
    case (op)
      2: begin out = s % 256; c = (s >= 256) ? 1 : 0; end
      3: out = a & b;
      4: out = a ^ b;
      5: out = b;
      default: out = a;
    endcase
    z = (a == 0) ? 1 : 0;
  endtask

  // Drive at negedge, check comb just after, check registered copy after posedge
  task automatic apply(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input int eo, input int ez, input int ec);
    @(negedge clk);
    inA = a; inB = b; opcode = op;
    #1;
    check({name, ".out"}, alu_out, eo);
    check({name, ".z"}, is_zero, ez);
    check({name, ".c"}, carry, ec);
    @(posedge clk);
    #1;
    check({name, ".out_r"}, alu_out_r, eo);
    check({name, ".z_r"}, is_zero_r, ez);
    check({name, ".c_r"}, carry_r, ec);
  endtask

  vec_t vecs[12];

  initial begin
    int eo, ez, ec;
    vecs[0]  = '{8'd5,   8'd10,  3'b010, 8'd15,  1'b0, 1'b0};
    vecs[1]  = '{8'hAA,  8'hCC,  3'b011, 8'h88,  1'b0, 1'b0};
    vecs[2]  = '{8'hFF,  8'h0F,  3'b100, 8'hF0,  1'b0, 1'b0};
    vecs[3]  = '{8'd8,   8'd2,   3'b001, 8'd8,   1'b0, 1'b0};
    vecs[4]  = '{8'd8,   8'd2,   3'b101, 8'd2,   1'b0, 1'b0};
    vecs[5]  = '{8'd8,   8'd2,   3'b000, 8'd8,   1'b0, 1'b0};
    vecs[6]  = '{8'd8,   8'd2,   3'b110, 8'd8,   1'b0, 1'b0};
    vecs[7]  = '{8'd8,   8'd2,   3'b111, 8'd8,   1'b0, 1'b0};
    vecs[8]  = '{8'd0,   8'd123, 3'b010, 8'd123, 1'b1, 1'b0};
    vecs[9]  = '{8'hFF,  8'hFF,  3'b100, 8'h00,  1'b0, 1'b0};
    vecs[10] = '{8'h00,  8'h00,  3'b101, 8'h00,  1'b1, 1'b0};
    vecs[11] = '{8'hFF,  8'h01,  3'b010, 8'h00,  1'b0, 1'b1};

    // Reset state with clock running
    @(posedge clk); #1;
    check("rst.out_r", alu_out_r, 0);
    check("rst.z_r", is_zero_r, 1);
    check("rst.c_r", carry_r, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
            vecs[i].out, vecs[i].z, vecs[i].c);

    // Non-zero result with carry held in the registers, then async reset mid-cycle
    apply("pre_rst", 8'hF0, 8'h20, 3'b010, 8'h10, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async.out_r", alu_out_r, 0);
    check("async.z_r", is_zero_r, 1);
    check("async.c_r", carry_r, 0);
    check("async.comb_out", alu_out, 8'h10);
    check("async.comb_c", carry, 1);
    @(posedge clk); #1;
    check("hold.out_r", alu_out_r, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release captures the current combinational values
    @(posedge clk); #1;
    check("rel.out_r", alu_out_r, 8'h10);
    check("rel.c_r", carry_r, 1);
    check("rel.z_r", is_zero_r, 0);

    // Randomized compare, biased toward zero and all-ones operands
    for (int n = 0; n < 300; n++) begin
      logic [7:0] a, b;
      logic [2:0] op;
      a  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      op = 3'($urandom);
      model(a, b, op, eo, ez, ec);
      apply($sformatf("rnd%0d", n), a, b, op, eo, ez, ec);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
